// File: rtl/mult_sched_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: FSM encoding and
// the expected request-to-response latency helper.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  // Cycles from the accepting handshake cycle to the first rsp_valid cycle:
  // LOAD, then TEST+SHIFT per bit, plus one ADD/SUB cycle per set bit of b.
  function automatic int ones_latency(input logic [31:0] b, input int width);
    int n;
    n = 0;
    for (int i = 0; i < width; i++) begin
      if (((b >> i) & 32'd1) != 32'd0) n++;
    end
    return 2 + 2 * width + n;
  endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Bundle of requester, datapath and response signals around mult_sched.
// Handshakes: a transfer happens on a rising Clk edge where valid and ready are
// both high; req_ready never depends on anything but req_valid and FSM state,
// and rsp_valid/rsp_data/rsp_id stay stable until rsp_ready is seen.
interface mult_sched_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
);
  import mult_sched_pkg::*;

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][WIDTH-1:0]  req_a;
  logic [NREQ-1:0][WIDTH-1:0]  req_b;

  logic [WIDTH-1:0]            dp_s;
  logic [WIDTH-1:0]            dp_b;
  logic                        dp_clr_ld;
  logic                        dp_add;
  logic                        dp_sub;
  logic                        dp_shift;
  logic                        dp_m;
  logic [2*WIDTH-1:0]          dp_result;

  logic                        rsp_valid;
  logic [IDW-1:0]              rsp_id;
  logic [2*WIDTH-1:0]          rsp_data;
  logic                        rsp_ready;

  logic                        busy;
  state_t                      state_dbg;

  // Environment side: requesters, datapath and response consumer.
  modport master (
    output req_valid, req_a, req_b, dp_m, dp_result, rsp_ready,
    input  req_ready, dp_s, dp_b, dp_clr_ld, dp_add, dp_sub, dp_shift,
           rsp_valid, rsp_id, rsp_data, busy, state_dbg
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, dp_m, dp_result, rsp_ready,
    output req_ready, dp_s, dp_b, dp_clr_ld, dp_add, dp_sub, dp_shift,
           rsp_valid, rsp_id, rsp_data, busy, state_dbg
  );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner (ptr) and
// returns a one-hot grant plus the encoded winner id.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any
);

  always_comb begin
    int idx;
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any && valid[IDW'(idx)]) begin
        grant[IDW'(idx)] = 1'b1;
        id               = IDW'(idx);
        any              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Sequencer/arbiter for the shared signed shift-add multiplier: grants one
// requester, steps the datapath through WIDTH iterations and returns the product.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) (
  input  logic      Clk,
  input  logic      Reset,
  mult_sched_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic             in_idle;
  logic             accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .grant (gnt),
    .id    (gnt_id),
    .any   (gnt_any)
  );

  // Grants are only offered while idle; Reset masks them combinationally.
  assign in_idle       = (state_q == S_IDLE) && !Reset;
  assign bus.req_ready = in_idle ? gnt : '0;
  assign accept        = in_idle && gnt_any;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
      id_q    <= '0;
      s_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      s_q     <= s_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    s_d     = s_q;
    b_d     = b_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          s_d     = bus.req_a[gnt_id];
          b_d     = bus.req_b[gnt_id];
          id_d    = gnt_id;
          ptr_d   = gnt_id;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_TEST;
      end
      // The last multiplier bit carries negative weight in two's complement.
      S_TEST: begin
        if (!bus.dp_m)               state_d = S_SHIFT;
        else if (cnt_q == CNT_LAST)  state_d = S_SUB;
        else                         state_d = S_ADD;
      end
      S_ADD:   state_d = S_SHIFT;
      S_SUB:   state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_TEST;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dp_clr_ld = 1'b0;
    bus.dp_add    = 1'b0;
    bus.dp_sub    = 1'b0;
    bus.dp_shift  = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_id    = '0;
    unique case (state_q)
      S_LOAD:  bus.dp_clr_ld = 1'b1;
      S_ADD:   bus.dp_add    = 1'b1;
      S_SUB:   bus.dp_sub    = 1'b1;
      S_SHIFT: bus.dp_shift  = 1'b1;
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = bus.dp_result;
        bus.rsp_id    = id_q;
      end
      default: ;
    endcase
  end

  assign bus.dp_s      = s_q;
  assign bus.dp_b      = b_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched with a behavioural A/B/X shift-add datapath.
module tb_mult_sched;
  import mult_sched_pkg::*;

  localparam int NREQ  = 2;
  localparam int WIDTH = 8;

  logic Clk;
  logic Reset;

  mult_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  mult_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- datapath model ----------------
  logic [7:0] m_a, m_b;
  logic       m_x;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_a <= '0; m_b <= '0; m_x <= 1'b0;
    end else if (bus.dp_clr_ld) begin
      m_a <= '0; m_x <= 1'b0; m_b <= bus.dp_b;
    end else if (bus.dp_add) begin
      {m_x, m_a} <= {m_a[7], m_a} + {bus.dp_s[7], bus.dp_s};
    end else if (bus.dp_sub) begin
      {m_x, m_a} <= {m_a[7], m_a} - {bus.dp_s[7], bus.dp_s};
    end else if (bus.dp_shift) begin
      m_a <= {m_x, m_a[7:1]};
      m_b <= {m_a[0], m_b[7:1]};
    end
  end

  assign bus.dp_m      = m_b[0];
  assign bus.dp_result = {m_a, m_b};

  // ---------------- counters / strobe monitor ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_clr, n_add, n_sub, n_shift, sub_at;

  always @(negedge Clk) begin
    if (!Reset) begin
      int ns;
      ns = int'(bus.dp_clr_ld) + int'(bus.dp_add) + int'(bus.dp_sub) + int'(bus.dp_shift);
      n_checks++;
      if (ns > 1) begin
        n_fail++;
        $display("FAIL strobe_overlap: %0d strobes high, required at most 1", ns);
      end
      if (ns > 0) begin
        n_checks++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_with_strobe: busy=%b, required 1", bus.busy);
        end
      end
      if (bus.dp_clr_ld) n_clr++;
      if (bus.dp_add)    n_add++;
      if (bus.dp_sub) begin n_sub++; sub_at = n_shift; end
      if (bus.dp_shift)  n_shift++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    n_clr = 0; n_add = 0; n_sub = 0; n_shift = 0; sub_at = -1;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Issue one request, wait for the response and leave it un-acknowledged.
  task automatic do_op(input logic [0:0] rid, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [15:0] data, output logic [0:0] id,
                       output int idle_cycles, output bit ok);
    int guard;
    ok = 1'b1; lat = 0; idle_cycles = 0; data = '0; id = '0;
    @(negedge Clk);
    bus.req_a[rid] = a;
    bus.req_b[rid] = b;
    bus.req_valid[rid] = 1'b1;
    #1;
    guard = 0;
    while (!bus.req_ready[rid] && guard < 100) begin
      @(negedge Clk); #1; guard++;
    end
    if (guard >= 100) begin
      ok = 1'b0;
      bus.req_valid[rid] = 1'b0;
      return;
    end
    @(posedge Clk);
    clear_counts();
    #1 bus.req_valid[rid] = 1'b0;
    lat = 1;
    guard = 0;
    while (guard < 200) begin
      @(negedge Clk);
      if (bus.rsp_valid) break;
      if (!bus.busy) idle_cycles++;
      @(posedge Clk);
      lat++;
      guard++;
    end
    if (guard >= 200) begin
      ok = 1'b0;
      return;
    end
    data = bus.rsp_data;
    id   = bus.rsp_id;
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge Clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    @(negedge Clk);
    n_checks++;
    if ({bus.req_ready, bus.dp_clr_ld, bus.dp_add, bus.dp_sub, bus.dp_shift,
         bus.rsp_valid, bus.busy, bus.rsp_data, bus.rsp_id, bus.dp_s, bus.dp_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_ready=%b strobes=%b%b%b%b rsp_valid=%b busy=%b rsp_data=%h dp_s=%h dp_b=%h, required all 0",
               bus.req_ready, bus.dp_clr_ld, bus.dp_add, bus.dp_sub, bus.dp_shift,
               bus.rsp_valid, bus.busy, bus.rsp_data, bus.dp_s, bus.dp_b);
    end
    Reset = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_tie: req_ready=%b, required 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_single();
    int lat, idle; logic [15:0] d; logic [0:0] id; bit ok;
    do_op(1'b0, 8'd7, 8'd3, lat, d, id, idle, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: no response, required one"); end
    n_checks++;
    if (d !== 16'd21) begin n_fail++; $display("FAIL single_data: got %h, required 0015", d); end
    n_checks++;
    if (id !== 1'b0) begin n_fail++; $display("FAIL single_id: got %0d, required 0", id); end
    n_checks++;
    if (lat !== 20) begin n_fail++; $display("FAIL single_latency: got %0d, required 20", lat); end
    n_checks++;
    if (n_clr !== 1 || n_shift !== 8 || n_add !== 2 || n_sub !== 0) begin
      n_fail++;
      $display("FAIL single_strobes: clr=%0d shift=%0d add=%0d sub=%0d, required 1 8 2 0",
               n_clr, n_shift, n_add, n_sub);
    end
    n_checks++;
    if (idle !== 0) begin n_fail++; $display("FAIL single_busy: %0d idle cycles, required 0", idle); end
    ack();
  endtask

  task automatic test_signed_corner();
    int lat, idle; logic [15:0] d; logic [0:0] id; bit ok;
    do_op(1'b0, 8'h80, 8'hFF, lat, d, id, idle, ok);
    n_checks++;
    if (!ok || d !== 16'h0080) begin
      n_fail++; $display("FAIL corner_data: got %h ok=%0d, required 0080", d, ok);
    end
    n_checks++;
    if (lat !== 26 || lat !== ones_latency(32'hFF, WIDTH)) begin
      n_fail++; $display("FAIL corner_latency: got %0d, required 26", lat);
    end
    n_checks++;
    if (n_sub !== 1 || sub_at !== 7) begin
      n_fail++; $display("FAIL corner_sub: count=%0d at shift %0d, required 1 at 7", n_sub, sub_at);
    end
    n_checks++;
    if (n_clr !== 1 || n_shift !== 8 || n_add !== 7 || idle !== 0) begin
      n_fail++;
      $display("FAIL corner_strobes: clr=%0d shift=%0d add=%0d idle=%0d, required 1 8 7 0",
               n_clr, n_shift, n_add, idle);
    end
    ack();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt [4];
    logic [15:0] exp_d   [2];
    int          exp_lat [2];
    int guard, lat;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    exp_d[0] = 16'hFFE2;  exp_d[1] = 16'hFFF4;
    exp_lat[0] = 24;      exp_lat[1] = 19;
    apply_reset();
    bus.req_a[0] = 8'd5;   bus.req_b[0] = 8'hFA;
    bus.req_a[1] = 8'hFD;  bus.req_b[1] = 8'd4;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int who;
      who = k % 2;
      #1;
      guard = 0;
      while (bus.req_ready === 2'b00 && guard < 50) begin
        @(negedge Clk); #1; guard++;
      end
      n_checks++;
      if (bus.req_ready !== exp_gnt[k]) begin
        n_fail++; $display("FAIL contention_grant%0d: got %b, required %b", k, bus.req_ready, exp_gnt[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (guard !== 0) begin
          n_fail++; $display("FAIL back_to_back%0d: grant after %0d extra cycles, required 0", k, guard);
        end
      end
      @(posedge Clk);
      lat = 1;
      guard = 0;
      while (guard < 200) begin
        @(negedge Clk);
        if (bus.rsp_valid) break;
        @(posedge Clk);
        lat++; guard++;
      end
      n_checks++;
      if (bus.rsp_id !== 1'(who) || bus.rsp_data !== exp_d[who] || lat !== exp_lat[who]) begin
        n_fail++;
        $display("FAIL contention_rsp%0d: id=%0d data=%h lat=%0d, required id=%0d data=%h lat=%0d",
                 k, bus.rsp_id, bus.rsp_data, lat, who, exp_d[who], exp_lat[who]);
      end
      ack();
      @(negedge Clk);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    int lat, idle; logic [15:0] d; logic [0:0] id; bit ok;
    do_op(1'b1, 8'd7, 8'd3, lat, d, id, idle, ok);
    n_checks++;
    if (!ok || d !== 16'd21 || id !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: data=%h id=%0d ok=%0d, required 0015 1 1", d, id, ok);
    end
    bus.req_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'd21 || bus.rsp_id !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%h id=%0d, required 1 0015 1",
                 c, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      n_checks++;
      if ({bus.dp_clr_ld, bus.dp_add, bus.dp_sub, bus.dp_shift} !== 4'b0000 ||
          bus.req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_quiet%0d: strobes=%b%b%b%b req_ready=%b, required 0",
                 c, bus.dp_clr_ld, bus.dp_add, bus.dp_sub, bus.dp_shift, bus.req_ready);
      end
    end
    bus.req_valid[0] = 1'b0;
    ack();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'd0 || bus.rsp_id !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b data=%h id=%0d busy=%b, required 0 0000 0 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int guard, lat, idle, stale; logic [15:0] d; logic [0:0] id; bit ok;
    @(negedge Clk);
    bus.req_a[0] = 8'd5; bus.req_b[0] = 8'd3; bus.req_valid[0] = 1'b1;
    @(posedge Clk);
    #1 bus.req_valid[0] = 1'b0;
    guard = 0;
    do begin
      @(negedge Clk); guard++;
    end while (!bus.dp_add && guard < 10);
    n_checks++;
    if (bus.dp_add !== 1'b1) begin
      n_fail++; $display("FAIL rst_reach_add: dp_add=%b, required 1", bus.dp_add);
    end
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.dp_clr_ld, bus.dp_add, bus.dp_sub, bus.dp_shift,
         bus.rsp_valid, bus.busy, bus.rsp_data, bus.rsp_id, bus.dp_s, bus.dp_b} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_outputs: strobes=%b%b%b%b busy=%b dp_s=%h dp_b=%h, required all 0",
               bus.dp_clr_ld, bus.dp_add, bus.dp_sub, bus.dp_shift, bus.busy, bus.dp_s, bus.dp_b);
    end
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    stale = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (bus.rsp_valid || bus.busy) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_fail++; $display("FAIL rst_no_stale: %0d active cycles, required 0", stale);
    end
    do_op(1'b0, 8'd2, 8'd2, lat, d, id, idle, ok);
    n_checks++;
    if (!ok || d !== 16'd4 || id !== 1'b0 || lat !== 19) begin
      n_fail++;
      $display("FAIL rst_after_op: data=%h id=%0d lat=%0d ok=%0d, required 0004 0 19 1", d, id, lat, ok);
    end
    ack();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    Reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    clear_counts();
    test_reset();
    test_single();
    test_signed_corner();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    repeat (2) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Sequencer and arbiter for the shared 8-bit signed shift-add multiplier datapath. Accepts multiply requests from NREQ requesters, grants one at a time in round-robin order, and latches its operands. Drives the datapath's clear/load, add, subtract and shift strobes through WIDTH iterations, then returns the 2·WIDTH-bit product tagged with the requester id. It sits between the requester ports and the multiplier datapath, which owns the A/B/X registers and the adder.

## Interface
- NREQ, 2, number of requesters (2..4)
- WIDTH, 8, operand width; product is 2·WIDTH
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot grant; at most one bit high
- req_a  in  NREQ×WIDTH  multiplicand (S) per requester
- req_b  in  NREQ×WIDTH  multiplier (B) per requester
- dp_s  out  WIDTH  latched multiplicand to datapath, held for whole operation
- dp_b  out  WIDTH  latched multiplier to datapath
- dp_clr_ld  out  1  clear A/X, load B
- dp_add / dp_sub / dp_shift  out  1 each  datapath strobes, mutually exclusive
- dp_m  in  1  current LSB of B register
- dp_result  in  2·WIDTH  {A,B} from datapath
- rsp_valid  out  1  product available
- rsp_id  out  clog2(NREQ)  id of requester owning product
- rsp_data  out  2·WIDTH  signed product
- rsp_ready  in  1  response consumer accepts
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, TEST, ADD, SUB, SHIFT, RESP. Outputs are Moore-decoded from state, except req_ready.
- IDLE: req_ready = round-robin grant over req_valid (combinational, may depend on req_valid). On handshake, latch req_a/req_b into dp_s/dp_b, record id, set rr pointer to id, and go to LOAD.
- LOAD: dp_clr_ld=1 for one cycle; iteration counter cnt←0; next state TEST.
- TEST: dp_m=1 and cnt<WIDTH-1 → ADD; dp_m=1 and cnt=WIDTH-1 → SUB; dp_m=0 → SHIFT.
- ADD: dp_add=1 for one cycle. SUB: dp_sub=1 for one cycle. Both go to SHIFT.
- SHIFT: dp_shift=1 for one cycle. If cnt=WIDTH-1 go to RESP, else cnt←cnt+1 and go to TEST.
- RESP: rsp_valid=1, rsp_data=dp_result, rsp_id=latched id. Hold until rsp_ready, then go to IDLE. No new grant is given in the same cycle.
- Round robin: search starts at (pointer+1) mod NREQ. After reset the pointer is NREQ-1, so requester 0 wins the first tie.
- cnt is clog2(WIDTH) bits and never wraps inside one operation.
- Outside RESP, rsp_data and rsp_id are 0. dp_s/dp_b hold their last latched value.

## Timing
- Reset: state IDLE, cnt 0, pointer NREQ-1, dp_s/dp_b 0. All strobes, rsp_valid, busy and req_ready are 0 while Reset is asserted.
- Latency: rsp_valid rises 2 + 2·WIDTH + ones(b) cycles after the accepting edge. For WIDTH=8 this is 18 cycles for b=0 and 26 cycles for b=0xFF.
- Back-to-back: the earliest next grant is the cycle after the RESP handshake.
- Request inputs are ignored outside IDLE; a requester's valid may stay high while it waits.
- Reset during any state aborts the operation immediately. The product is discarded and no response is issued.
- Holding rsp_ready=0 stalls indefinitely with no strobes asserted. The datapath result is stable during the stall.

## Structure
- mult_sched_pkg: the state enum and the helper function ones_latency(b, WIDTH) shared with the bench.
- Sub-module rr_arbiter (NREQ): takes valid vector and pointer, returns one-hot grant and encoded id.
- The top level holds the FSM, counter, operand and id registers, and the output decode.

## Test plan
- Single request: req 0 with a=7, b=3 → rsp_data=21, rsp_id=0; rsp_valid at accept+20.
- Signed corner: a=-128 (0x80), b=-1 (0xFF) → rsp_data=128 (0x0080). SUB occurs exactly once, on the cnt=7 iteration.
- Contention: req 0 and req 1 valid together from reset → grants in order 0,1,0,1 across four operations. Results for a0=5, b0=-6 (−30) and a1=-3, b1=4 (−12) are correctly tagged.
- Backpressure: rsp_ready low for 10 cycles → rsp_valid, rsp_data and rsp_id stable, no strobes, req_ready=0 throughout.
- Reset mid-operation: assert Reset in the ADD state → all outputs 0 asynchronously. After release, a new request with a=2, b=2 yields 4 with no stale response.
- Strobe checker for every run: exactly one dp_clr_ld per operation, WIDTH shifts, strobes never overlap, and busy=1 from LOAD through RESP.
